spike_window_classifier: RTL
============================

// Module: spike_window_classifier
// PURPOSE
//   Sequences one inference window for the SNN digit classifier. Accumulates per-class
//   output spikes over WINDOW_LEN accepted timesteps, then runs a sequential argmax
//   (one compare per cycle). Presents the predicted digit and its count on a valid/ready
//   result port. Sits between the output-neuron layer and the top-level I/O.
// PARAMETERS
//   NUM_CLASSES  10   number of output neurons/classes (2..16)
//   COUNT_W      8    per-class spike counter width (saturating)
//   WINDOW_LEN   100  accepted timesteps per inference window (>=1)
// PORTS
//   clk            in   1            single clock, rising edge
//   rst_n          in   1            asynchronous active-low reset
//   start          in   1            begin new window (sampled only in IDLE)
//   step_valid     in   1            spikes[] holds one valid timestep this cycle
//   spikes         in   NUM_CLASSES  per-class spike bits for this timestep
//   busy           out  1            high in ACCUM or SCAN
//   result_valid   out  1            result_digit/result_count valid (DONE state)
//   result_ready   in   1            consumer accepts result
//   result_digit   out  4            winning class index
//   result_count   out  COUNT_W      spike count of winning class
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; all counters, step counter, scan index,
//     result_digit, result_count = 0; busy=0, result_valid=0. Applies mid-window too;
//     any partial window is discarded.
//   FSM IDLE -> ACCUM -> SCAN -> DONE -> IDLE.
//   IDLE: start=1 -> clear all class counters and step counter; next state ACCUM.
//     start ignored in every other state.
//   ACCUM: step_valid=1 -> for each i with spikes[i]=1, cnt[i]+=1, saturating at
//     2^COUNT_W-1; step counter +1. step_valid=0 -> no change (stall, no timeout).
//     Step accepted as number WINDOW_LEN -> next state SCAN. spikes[] ignored
//     whenever step_valid=0 or state!=ACCUM.
//   SCAN: best_idx=0, best=cnt[0] on entry; idx = 1..NUM_CLASSES-1, one per cycle;
//     update best only if cnt[idx] > best (strict). Ties keep lower index; all-zero
//     counts -> digit 0. After idx=NUM_CLASSES-1 -> DONE.
//   Latency: last step accepted in cycle T -> SCAN in cycles T+1..T+NUM_CLASSES-1 ->
//     result_valid=1 from cycle T+NUM_CLASSES (T+10 at default).
//   DONE: result_valid=1, result_digit/result_count stable and held until
//     result_valid&&result_ready; that edge -> IDLE, result_valid=0 next cycle.
//     result_digit/result_count keep last value in IDLE; overwritten only at SCAN end.
//   result_ready ignored outside DONE. start in the handshake cycle is ignored
//     (new window needs start in IDLE).
//   Step counter width = $clog2(WINDOW_LEN+1); internal scan index 4 bits.
// TESTING
//   Run all with WINDOW_LEN=8, NUM_CLASSES=10, COUNT_W=8 unless stated.
//   1 Class 7 spikes every step, others never, 8 steps -> digit 7, count 8, valid
//     exactly 10 cycles after last step.
//   2 Classes 3 and 5 each spike all 8 steps -> digit 3 (tie to lower); no spikes at
//     all -> digit 0, count 0.
//   3 step_valid toggled 1/0 each cycle -> window ends on 8th accepted step only;
//     counts ignore spikes[] on step_valid=0 cycles.
//   4 WINDOW_LEN=300, class 9 every step -> count saturates at 255, digit 9.
//   5 Hold result_ready=0 for 20 cycles in DONE -> outputs stable, start pulses ignored;
//     ready=1 -> IDLE; next start with class 2 winning -> digit 2, no stale counts.
//   6 rst_n low mid-ACCUM (step 4) and mid-SCAN -> all outputs 0 immediately; fresh
//     start gives correct result from clean counters.

Source files
------------

// File: rtl/spike_window_classifier_if.sv
// spike_window_classifier_if: start/step/result bundle between the output-neuron layer and classifier
//   start, step_valid, spikes[NUM_CLASSES], result_ready : master -> slave
//   busy, result_valid, result_digit[4], result_count    : slave -> master
interface spike_window_classifier_if #(
  parameter int NUM_CLASSES = 10,
  parameter int COUNT_W     = 8
);
  logic                   start;
  logic                   step_valid;
  logic [NUM_CLASSES-1:0] spikes;
  logic                   busy;
  logic                   result_valid;
  logic                   result_ready;
  logic [3:0]             result_digit;
  logic [COUNT_W-1:0]     result_count;
  modport master (
    output start, step_valid, spikes, result_ready,
    input  busy, result_valid, result_digit, result_count
  );
  modport slave (
    input  start, step_valid, spikes, result_ready,
    output busy, result_valid, result_digit, result_count
  );
endinterface

// File: rtl/spike_window_classifier.sv
// spike_window_classifier: accumulates per-class spikes over a window, then sequential argmax
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of spike_window_classifier_if (start/steps in, result valid/ready out)
module spike_window_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int COUNT_W     = 8,
  parameter int WINDOW_LEN  = 100
) (
  input  logic clk,
  input  logic rst_n,
  spike_window_classifier_if.slave bus
);
  localparam int STEP_W = $clog2(WINDOW_LEN + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WINDOW_LEN - 1);
  localparam logic [3:0] IDX_LAST = 4'(NUM_CLASSES - 1);
  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;
  state_t             state_q, state_d;
  logic [COUNT_W-1:0] cnt_q [NUM_CLASSES];
  logic [COUNT_W-1:0] cnt_d [NUM_CLASSES];
  logic [STEP_W-1:0]  step_q, step_d;
  logic [3:0]         idx_q, idx_d;
  logic [COUNT_W-1:0] best_q, best_d;
  logic [3:0]         best_idx_q, best_idx_d;
  logic [3:0]         digit_q, digit_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] cur;
  logic               hit;
  assign cur = cnt_q[idx_q];
  // strict compare so ties keep the lower index
  assign hit = cur > best_q;
  assign bus.busy         = (state_q == ACCUM) || (state_q == SCAN);
  assign bus.result_valid = state_q == DONE;
  assign bus.result_digit = digit_q;
  assign bus.result_count = count_q;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    idx_d      = idx_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    digit_d    = digit_q;
    count_d    = count_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = ACCUM;
        cnt_d   = '{default: '0};
        step_d  = '0;
      end
      ACCUM: if (bus.step_valid) begin
        for (int i = 0; i < NUM_CLASSES; i++)
          cnt_d[i] = (bus.spikes[i] && !(&cnt_q[i])) ? cnt_q[i] + 1'b1 : cnt_q[i];
        step_d = step_q + 1'b1;
        // seed the scan with class 0 including this final step's increment
        if (step_q == STEP_LAST) begin
          state_d    = SCAN;
          idx_d      = 4'd1;
          best_d     = cnt_d[0];
          best_idx_d = '0;
        end
      end
      SCAN: begin
        best_d     = hit ? cur : best_q;
        best_idx_d = hit ? idx_q : best_idx_q;
        idx_d      = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          idx_d   = idx_q;
          digit_d = best_idx_d;
          count_d = best_d;
        end
      end
      DONE: if (bus.result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '{default: '0};
      step_q     <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      digit_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      digit_q    <= digit_d;
      count_q    <= count_d;
    end
  end
endmodule
